l2_flush_ctrl: RTL and testbench
================================

Name: l2_flush_ctrl

Overview:
- Sequences L2 flush operations by walking every (set, way) of the L2 and issuing one line-flush command per entry to the L2 core datapath.
- Sits between the flush request interface (l2_flush_valid/l2_flush_i) and the core's flush lookup/evict path, replacing the tied-off ongoing_flush / flush_set / flush_way controls in l2_core.
- Signals completion with flush_done (full flush) or acc_flush_done (accelerator flush).

Parameters:
L2_SETS, 256, number of sets; power of two, >= 2
L2_WAYS, 8, number of ways; power of two, >= 2
SET_BITS, $clog2(L2_SETS), set index width
WAY_BITS, $clog2(L2_WAYS), way index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
l2_flush_valid  in  1  flush request valid
l2_flush_i  in  1  flush type: 1 = full flush, 0 = accelerator flush
l2_flush_ready  out  1  flush request accepted when valid & ready
idle  in  1  core has no outstanding MSHR entries and no in-flight request
fwd_pending  in  1  forward or response waiting at core input; pauses issue
flush_line_valid  out  1  line-flush command valid
flush_line_ready  in  1  core accepts command this cycle
flush_line_set  out  SET_BITS  set index of command
flush_line_way  out  WAY_BITS  way index of command
flush_line_all  out  1  captured flush type, held for the whole operation
flush_line_done  in  1  pulse: accepted line finished (written back or invalidated)
flush_line_retry  in  1  pulse: accepted line could not complete (MSHR full); reissue same line
ongoing_flush  out  1  high from acceptance until the done pulse, inclusive
flush_done  out  1  one-cycle pulse, full flush complete
acc_flush_done  out  1  one-cycle pulse, accelerator flush complete

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; set_cnt=0, way_cnt=0, type_reg=0. All outputs 0 except l2_flush_ready=1. A flush in progress is abandoned with no done pulse.
- Counters: set_cnt is SET_BITS+1 wide, way_cnt is WAY_BITS+1 wide. flush_line_set and flush_line_way are the low bits.
- Walk order: way is the inner loop, set the outer loop: (0,0),(0,1)..(0,W-1),(1,0).. The last line is (S-1,W-1).
- IDLE:
  - l2_flush_ready=1.
  - On valid&ready: capture type_reg=l2_flush_i, clear both counters, go to DRAIN.
  - ongoing_flush=1 from the next cycle.
- DRAIN:
  - l2_flush_ready=0.
  - Wait for idle=1, then go to ISSUE the following cycle.
  - If idle is already 1 on entry, spend exactly one cycle in DRAIN.
- ISSUE:
  - flush_line_valid = ~fwd_pending.
  - Command fields are stable while valid is held.
  - On valid&ready, go to WAIT.
  - A deasserting fwd_pending resumes issue with the same indices; no command is lost.
- WAIT:
  - flush_line_valid=0.
  - On flush_line_retry, go back to ISSUE with unchanged indices.
  - On flush_line_done:
    - If the line was not the last: way_cnt+1. If way_cnt was W-1, way_cnt=0 and set_cnt+1. Go to ISSUE.
    - If the line was the last: go to DONE.
  - If retry and done are asserted together, retry wins.
- done/retry outside WAIT are ignored.
- DONE:
  - One cycle. flush_done=type_reg, acc_flush_done=~type_reg, ongoing_flush=1.
  - Next state IDLE; ongoing_flush=0 and l2_flush_ready=1 from that cycle.
- Exactly one command is outstanding at a time. Minimum per-line latency is 2 cycles (ISSUE accept, WAIT done).
- An uninterrupted flush of N=L2_SETS*L2_WAYS lines with immediate ready and done takes 2N+2 cycles from the acceptance edge to the DONE pulse:
  - 1 cycle DRAIN (idle=1 on entry);
  - 2N cycles of ISSUE/WAIT;
  - the DONE cycle is the (2N+2)th.
- l2_flush_valid during a flush is not accepted (ready=0). The request stays pending and is taken in the IDLE cycle after DONE.
- l2_flush_i changes after acceptance have no effect.

Test Plan:
- L2_SETS=4, L2_WAYS=2, idle=1, ready=1, done returned the cycle after accept, l2_flush_i=1 -> commands (0,0),(0,1),(1,0)..(3,1) in order, flush_line_all=1, flush_done pulse exactly 18 cycles after acceptance, acc_flush_done stays 0.
- Same config, l2_flush_i=0, idle held 0 for 5 cycles after acceptance -> no flush_line_valid during those 5 cycles; walk starts the cycle after idle=1; acc_flush_done=1 pulse, flush_done=0.
- flush_line_retry on line (2,1) three times, then done -> (2,1) issued 4 times; next command is (3,0); total of 8 unique lines, 11 commands.
- fwd_pending=1 for 4 cycles while in ISSUE at (1,0) -> flush_line_valid=0 during those cycles, indices stay (1,0), and issue resumes unchanged.
- Second l2_flush_valid held high during a flush -> l2_flush_ready=0 until DONE; accepted in the next cycle; the second walk restarts at (0,0).
- rst asserted while WAIT at (1,1) -> outputs reset asynchronously; no done pulse; after release, l2_flush_ready=1 and a new flush starts at (0,0).

Source files
------------

// File: rtl/l2_flush_ctrl.sv
// l2_flush_ctrl: walks every (set, way) of the L2, one line-flush command outstanding at a time,
// and pulses flush_done / acc_flush_done when the last line has finished.
module l2_flush_ctrl #(
  parameter int L2_SETS  = 256,
  parameter int L2_WAYS  = 8,
  parameter int SET_BITS = $clog2(L2_SETS),
  parameter int WAY_BITS = $clog2(L2_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                l2_flush_valid,
  input  logic                l2_flush_i,
  output logic                l2_flush_ready,
  input  logic                idle,
  input  logic                fwd_pending,
  output logic                flush_line_valid,
  input  logic                flush_line_ready,
  output logic [SET_BITS-1:0] flush_line_set,
  output logic [WAY_BITS-1:0] flush_line_way,
  output logic                flush_line_all,
  input  logic                flush_line_done,
  input  logic                flush_line_retry,
  output logic                ongoing_flush,
  output logic                flush_done,
  output logic                acc_flush_done
);
  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t            state, state_nx;
  logic [SET_BITS:0] set_cnt, set_nx;
  logic [WAY_BITS:0] way_cnt, way_nx;
  logic              type_reg, type_nx;
  logic              last_way, last_line;
  assign last_way  = way_cnt[WAY_BITS-1:0] == WAY_BITS'(L2_WAYS - 1);
  assign last_line = last_way && set_cnt[SET_BITS-1:0] == SET_BITS'(L2_SETS - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      set_cnt  <= '0;
      way_cnt  <= '0;
      type_reg <= 1'b0;
    end else begin
      state    <= state_nx;
      set_cnt  <= set_nx;
      way_cnt  <= way_nx;
      type_reg <= type_nx;
    end
  end
  // Retry takes priority over done so a failed line is always reissued with unchanged indices.
  always_comb begin
    state_nx = state;
    set_nx   = set_cnt;
    way_nx   = way_cnt;
    type_nx  = type_reg;
    case (state)
      S_IDLE: if (l2_flush_valid) begin
        state_nx = S_DRAIN;
        type_nx  = l2_flush_i;
        set_nx   = '0;
        way_nx   = '0;
      end
      S_DRAIN: state_nx = idle ? S_ISSUE : S_DRAIN;
      S_ISSUE: state_nx = (flush_line_valid && flush_line_ready) ? S_WAIT : S_ISSUE;
      S_WAIT: if (flush_line_retry) state_nx = S_ISSUE;
        else if (flush_line_done) begin
          state_nx = last_line ? S_DONE : S_ISSUE;
          way_nx   = (last_line || last_way) ? '0 : way_cnt + 1'b1;
          set_nx   = (!last_line && last_way) ? set_cnt + 1'b1 : set_cnt;
        end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  assign l2_flush_ready   = state == S_IDLE;
  assign ongoing_flush    = state != S_IDLE;
  assign flush_line_valid = state == S_ISSUE && !fwd_pending;
  assign flush_line_set   = set_cnt[SET_BITS-1:0];
  assign flush_line_way   = way_cnt[WAY_BITS-1:0];
  assign flush_line_all   = type_reg;
  assign flush_done       = state == S_DONE && type_reg;
  assign acc_flush_done   = state == S_DONE && !type_reg;
endmodule

// File: tb/tb_l2_flush_ctrl.sv
// tb_l2_flush_ctrl: scoreboard bench; the model expects lines 0..N-1 in order (set = id/W, way = id%W),
// with retried lines pushed back to the front, and one done pulse of the captured type per accepted request.
module tb_l2_flush_ctrl;
  localparam int S = 4, W = 2, N = S * W, SB = $clog2(S), WB = $clog2(W);
  logic clk = 0, rst = 1, l2_flush_valid = 0, l2_flush_i = 0, idle = 1, fwd_pending = 0;
  logic flush_line_ready = 1, flush_line_done = 0, flush_line_retry = 0;
  logic l2_flush_ready, flush_line_valid, flush_line_all, ongoing_flush, flush_done, acc_flush_done;
  logic [SB-1:0] flush_line_set;
  logic [WB-1:0] flush_line_way;
  int total = 0, bad = 0;
  int exp_q[$];
  bit type_q[$];
  bit cur_type, mon_t, busy, in_wait, idle_seen, hold_chk, lat_chk, acc_seen, rnd;
  int cyc = 0, acc_edge, drain_extra, cmd_cnt, retries, n_acc = 0, n_done = 0, fwd_seen = 0, acc_line;
  bit outst, wait_now, fwd_start;
  int dly, cur, wait_line, retry_line = -1, retry_left = 0, fwd_line = -1, fwd_left = 0;
  int exp_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  l2_flush_ctrl #(.L2_SETS(S), .L2_WAYS(W)) dut (
    .clk(clk), .rst(rst), .l2_flush_valid(l2_flush_valid), .l2_flush_i(l2_flush_i),
    .l2_flush_ready(l2_flush_ready), .idle(idle), .fwd_pending(fwd_pending),
    .flush_line_valid(flush_line_valid), .flush_line_ready(flush_line_ready),
    .flush_line_set(flush_line_set), .flush_line_way(flush_line_way), .flush_line_all(flush_line_all),
    .flush_line_done(flush_line_done), .flush_line_retry(flush_line_retry),
    .ongoing_flush(ongoing_flush), .flush_done(flush_done), .acc_flush_done(acc_flush_done));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops expected commands and done pulses.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      busy = 0; in_wait = 0; acc_seen = 0; hold_chk = 0;
      exp_q.delete(); type_q.delete();
      continue;
    end
    chk("ready", l2_flush_ready, !busy);
    chk("ongoing", ongoing_flush, busy);
    if (hold_chk) begin
      chk("pending_req_taken_after_done", l2_flush_valid && l2_flush_ready, 1);
      hold_chk = 0;
    end
    if (fwd_pending) chk("fwd_blocks_valid", flush_line_valid, 0);
    if (fwd_pending && busy) fwd_seen++;
    if (fwd_pending && busy && !in_wait && exp_q.size() > 0) begin
      chk("fwd_hold_set", flush_line_set, exp_q[0] / W);
      chk("fwd_hold_way", flush_line_way, exp_q[0] % W);
    end
    if (flush_line_valid) chk("valid_after_drain", idle_seen, 1);
    if (busy && !idle_seen) begin
      if (idle) idle_seen = 1;
      else drain_extra++;
    end
    if (in_wait && (flush_line_done || flush_line_retry)) in_wait = 0;
    if (flush_line_valid) begin
      if (exp_q.size() == 0) chk("unexpected_cmd", 1, 0);
      else begin
        chk("cmd_set", flush_line_set, exp_q[0] / W);
        chk("cmd_way", flush_line_way, exp_q[0] % W);
        chk("cmd_all", flush_line_all, cur_type);
        if (flush_line_ready) begin
          acc_line = exp_q.pop_front();
          acc_seen = 1; in_wait = 1; cmd_cnt++;
        end
      end
    end
    if (flush_done || acc_flush_done) begin
      if (type_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_t = type_q.pop_front();
        chk("flush_done", flush_done, mon_t);
        chk("acc_flush_done", acc_flush_done, !mon_t);
        chk("lines_left_at_done", exp_q.size(), 0);
        chk("cmd_count", cmd_cnt, N + retries);
        if (lat_chk) chk("done_latency", cyc - acc_edge + 1, 2 * N + 2 + drain_extra);
      end
      n_done++; busy = 0; hold_chk = l2_flush_valid;
    end
    if (l2_flush_valid && l2_flush_ready) begin
      busy = 1; cur_type = l2_flush_i; type_q.push_back(l2_flush_i);
      for (int i = 0; i < N; i++) exp_q.push_back(i);
      acc_edge = cyc + 1; drain_extra = 0; idle_seen = 0; cmd_cnt = 0; retries = 0; n_acc++;
    end
  end

  // Core responder: drives ready/done/retry/fwd_pending just after each rising edge.
  initial forever begin
    @(posedge clk); #1;
    flush_line_done = 0; flush_line_retry = 0; wait_now = 0;
    if (!rst) begin
      outst = 0; fwd_left = 0; fwd_start = 0; fwd_pending = 0;
      continue;
    end
    flush_line_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
    if (fwd_start) begin fwd_left = 4; fwd_start = 0; end
    fwd_pending = fwd_left > 0 || (rnd && $urandom_range(4) == 0);
    if (fwd_left > 0) fwd_left--;
    if (acc_seen) begin
      acc_seen = 0; outst = 1; cur = acc_line; wait_now = 1; wait_line = cur;
      dly = rnd ? int'($urandom_range(2)) : 0;
    end
    if (outst) begin
      if (dly > 0) dly--;
      else begin
        outst = 0;
        if ((cur == retry_line && retry_left > 0) || (rnd && $urandom_range(3) == 0)) begin
          if (cur == retry_line && retry_left > 0) retry_left--;
          flush_line_retry = 1;
          flush_line_done = rnd && $urandom_range(1) == 1;
          exp_q.push_front(cur);
          retries++;
        end else begin
          flush_line_done = 1;
          if (cur == fwd_line) fwd_start = 1;
        end
      end
    end else if (rnd && $urandom_range(9) == 0) begin
      if ($urandom_range(1) == 1) flush_line_done = 1;
      else flush_line_retry = 1;
    end
  end

  task automatic req(input bit t);
    int a = n_acc;
    @(posedge clk); #2;
    l2_flush_valid = 1; l2_flush_i = t;
    for (int i = 0; i < 500 && n_acc == a; i++) @(negedge clk);
    chk("req_accept_timeout", n_acc != a, 1);
    @(posedge clk); #2;
    l2_flush_valid = 0; l2_flush_i = $urandom_range(1);
    exp_done++;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && n_done < exp_done; i++) @(negedge clk);
    chk("done_timeout", n_done >= exp_done, 1);
  endtask

  initial begin
    int a, d;
    #1 rst = 0;
    #1;
    chk("rst_ready", l2_flush_ready, 1);
    chk("rst_ongoing", ongoing_flush, 0);
    chk("rst_valid", flush_line_valid, 0);
    chk("rst_done", flush_done, 0);
    chk("rst_acc_done", acc_flush_done, 0);
    chk("rst_set", flush_line_set, 0);
    chk("rst_way", flush_line_way, 0);
    chk("rst_all", flush_line_all, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1;
    // full flush, no stalls: DONE in cycle 2N+2 after acceptance
    lat_chk = 1;
    req(1); wait_done();
    // accelerator flush with idle held low for 5 cycles
    idle = 0;
    req(0);
    repeat (5) @(posedge clk);
    #2 idle = 1;
    wait_done();
    lat_chk = 0;
    // three retries on (2,1)
    retry_line = 2 * W + 1; retry_left = 3;
    req(1); wait_done();
    chk("retry_cmds", cmd_cnt, 11);
    chk("retry_all_used", retry_left, 0);
    retry_line = -1;
    // fwd_pending for 4 cycles while issuing (1,0)
    fwd_line = 1; fwd_seen = 0;
    req(0); wait_done();
    chk("fwd_cycles", fwd_seen, 4);
    fwd_line = -1;
    // second request held through a flush
    a = n_acc;
    @(posedge clk); #2;
    l2_flush_valid = 1; l2_flush_i = 1;
    for (int i = 0; i < 500 && n_acc == a; i++) @(negedge clk);
    @(posedge clk); #2 l2_flush_i = 0;
    for (int i = 0; i < 500 && n_acc < a + 2; i++) @(negedge clk);
    chk("second_req_accepted", n_acc, a + 2);
    @(posedge clk); #2 l2_flush_valid = 0;
    exp_done += 2;
    wait_done();
    // reset while waiting on (1,1)
    req(1);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #3;
      if (wait_now && wait_line == W + 1) break;
    end
    chk("reached_wait_11", wait_now && wait_line == W + 1, 1);
    d = n_done;
    rst = 0;
    #1;
    chk("arst_ready", l2_flush_ready, 1);
    chk("arst_ongoing", ongoing_flush, 0);
    chk("arst_valid", flush_line_valid, 0);
    chk("arst_done", flush_done | acc_flush_done, 0);
    chk("arst_set", flush_line_set, 0);
    chk("arst_way", flush_line_way, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1;
    exp_done = d;
    repeat (4) @(negedge clk);
    chk("no_done_after_reset", n_done, d);
    req(0); wait_done();
    // randomized flushes
    rnd = 1;
    for (int k = 0; k < 6; k++) begin
      idle = 0;
      req($urandom_range(1));
      repeat ($urandom_range(3)) @(posedge clk);
      #2 idle = 1;
      wait_done();
    end
    rnd = 0;
    repeat (4) @(negedge clk);
    chk("end_cmd_queue_empty", exp_q.size(), 0);
    chk("end_done_queue_empty", type_q.size(), 0);
    chk("end_done_count", n_done, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
